stack_alu: RTL

Parametrised signed stack calculator with a valid/ready command interface and an iterative signed multiplier. It generalises the original 32-bit/16-deep stack in three ways: it adds SUB, DUP, SWAP and NOP, it reports errors explicitly, and it applies backpressure during multi-cycle operations. It sits between a command sequencer and the result consumer. All stack state is local to the block.

---
 rtl/stack_alu_pkg.sv | 12 +
 rtl/stack_alu_seq_mul.sv | 50 +++++
 rtl/stack_alu.sv | 120 ++++++++++++
 3 files changed

// File: rtl/stack_alu_pkg.sv
// stack_alu_pkg: opcodes and control states shared by the stack calculator.
package stack_alu_pkg;
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_DUP  = 3'b010;
  localparam logic [2:0] OP_SWAP = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;
  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_DONE} state_t;
endpackage

// File: rtl/stack_alu_seq_mul.sv
// seq_mul_signed: radix-2 shift-add multiplier on operand magnitudes, one multiplier bit per cycle.
module seq_mul_signed #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic                      busy,
  output logic                      done,
  output logic [2*DATA_WIDTH-1:0]   product
);
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(W);
  logic [W-1:0] a_mag, b_mag, mcand, mplier;
  logic [2*W-1:0] acc;
  logic [CW-1:0] cnt;
  logic neg;
  assign a_mag = a[W-1] ? -a : a;
  assign b_mag = b[W-1] ? -b : b;
  assign product = neg ? -acc : acc;
  // MSB-first: the capture cycle already folds in the top multiplier bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      neg <= 1'b0;
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
    end else begin
      done <= busy && cnt == CW'(W - 1);
      if (start) begin
        mcand <= a_mag;
        mplier <= b_mag << 1;
        acc <= b_mag[W-1] ? {{W{1'b0}}, a_mag} : '0;
        neg <= a[W-1] ^ b[W-1];
        cnt <= CW'(1);
        busy <= 1'b1;
      end else if (busy) begin
        acc <= {acc[2*W-2:0], 1'b0} + (mplier[W-1] ? {{W{1'b0}}, mcand} : '0);
        mplier <= mplier << 1;
        cnt <= cnt + CW'(1);
        busy <= cnt != CW'(W - 1);
      end
    end
  end
endmodule

// File: rtl/stack_alu.sv
// stack_alu: signed stack calculator with a valid/ready command port and a sequential multiplier.
module stack_alu
  import stack_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STACK_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   opcode,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         result_valid,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         error,
  output logic [$clog2(STACK_DEPTH):0] sp
);
  localparam int W = DATA_WIDTH;
  localparam int AW = $clog2(STACK_DEPTH);
  localparam int SW = AW + 1;
  state_t state, state_nxt;
  logic [W-1:0] mem [STACK_DEPTH];
  logic [AW-1:0] t_idx, n_idx, wa_idx;
  logic [W-1:0] t, n, sum, diff, res;
  logic [SW-1:0] sp_nxt;
  logic [2*W-1:0] mul_prod;
  logic fire, illegal, mul_go, complete, ovf, wa_en, wb_en;
  logic add_ovf, sub_ovf, mul_ovf, mul_busy, mul_done;
  assign t_idx = AW'(sp - SW'(1));
  assign n_idx = AW'(sp - SW'(2));
  assign t = mem[t_idx];
  assign n = mem[n_idx];
  assign sum = n + t;
  assign diff = n - t;
  assign add_ovf = (n[W-1] == t[W-1]) && (sum[W-1] != n[W-1]);
  assign sub_ovf = (n[W-1] != t[W-1]) && (diff[W-1] != n[W-1]);
  assign mul_ovf = mul_prod[2*W-1:W] != {W{mul_prod[W-1]}};
  assign illegal = (opcode == OP_PUSH) ? full
                 : (opcode == OP_POP)  ? empty
                 : (opcode == OP_DUP)  ? (empty || full)
                 : (opcode == OP_NOP)  ? 1'b0
                 : (sp < SW'(2));
  assign fire = cmd_valid && cmd_ready;
  assign mul_go = fire && opcode == OP_MUL && !illegal;
  assign complete = state == MUL_DONE || (fire && !mul_go);
  seq_mul_signed #(.DATA_WIDTH(W)) u_mul (
    .clk(clk),
    .rst_n(rst_n),
    .start(mul_go),
    .a(n),
    .b(t),
    .busy(mul_busy),
    .done(mul_done),
    .product(mul_prod)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE    ? (mul_go ? MUL_RUN : IDLE)
              : state == MUL_RUN ? (mul_done ? MUL_DONE : MUL_RUN)
              : IDLE;
  end
  always_comb begin
    cmd_ready = state == IDLE && !mul_busy;
  end
  // Every write lands the op's result, so one data path serves all writers; SWAP also needs a second port.
  always_comb begin
    res = data_out;
    ovf = 1'b0;
    sp_nxt = sp;
    wa_en = 1'b0;
    wb_en = 1'b0;
    wa_idx = n_idx;
    if (state == MUL_DONE) begin
      res = mul_prod[W-1:0];
      ovf = mul_ovf;
      sp_nxt = sp - SW'(1);
      wa_en = 1'b1;
    end else if (fire && !illegal) begin
      case (opcode)
        OP_PUSH: begin res = data_in; sp_nxt = sp + SW'(1); wa_en = 1'b1; wa_idx = sp[AW-1:0]; end
        OP_POP:  begin res = t; sp_nxt = sp - SW'(1); end
        OP_DUP:  begin res = t; sp_nxt = sp + SW'(1); wa_en = 1'b1; wa_idx = sp[AW-1:0]; end
        OP_SWAP: begin res = n; wa_en = 1'b1; wa_idx = t_idx; wb_en = 1'b1; end
        OP_ADD:  begin res = sum; ovf = add_ovf; sp_nxt = sp - SW'(1); wa_en = 1'b1; end
        OP_SUB:  begin res = diff; ovf = sub_ovf; sp_nxt = sp - SW'(1); wa_en = 1'b1; end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (wa_en) mem[wa_idx] <= res;
    if (wb_en) mem[n_idx] <= t;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      data_out <= '0;
      result_valid <= 1'b0;
      overflow <= 1'b0;
      error <= 1'b0;
    end else begin
      sp <= sp_nxt;
      empty <= sp_nxt == '0;
      full <= sp_nxt == SW'(STACK_DEPTH);
      data_out <= res;
      result_valid <= complete;
      overflow <= complete ? ovf : overflow;
      error <= complete ? (fire && illegal) : error;
    end
  end
endmodule
